// File: rtl/player_pkg.sv
// player_pkg
//   Shared types and constants for the player movement scheduler.
//   move_t   : queued move command (2 bits).
//   state_t  : scheduler run state (RUN / FROZEN).
//   DROP_MAX : saturation value of the dropped-request counter.
//   decode_req() turns a left/right request pair into a move command;
//   simultaneous requests cancel each other.
package player_pkg;

  typedef enum logic [1:0] {
    MV_NONE  = 2'd0,
    MV_LEFT  = 2'd1,
    MV_RIGHT = 2'd2
  } move_t;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic move_t decode_req(input logic left_req, input logic right_req);
    move_t cmd;
    cmd = MV_NONE;
    if (left_req && !right_req) begin
      cmd = MV_LEFT;
    end else if (right_req && !left_req) begin
      cmd = MV_RIGHT;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo
//   DEPTH-entry synchronous FIFO of move_t commands with a registered
//   show-ahead head output.
//   Ports:
//     CLK, RST     : clock, synchronous active-high reset
//     push, din    : write din at the tail (accepted when not full, or when
//                    a pop happens in the same cycle)
//     pop          : remove the head entry (ignored when empty)
//     flush        : empty the FIFO; overrides push and pop
//     head         : current head entry (valid when !empty)
//     empty, full  : occupancy flags, derived from the count register
module move_fifo
  import player_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  push,
  input  move_t din,
  input  logic  pop,
  input  logic  flush,
  output move_t head,
  output logic  empty,
  output logic  full
);

  // DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  move_t          mem_reg [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  move_t          head_reg, head_next;
  logic           push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_FULL);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign head    = head_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
    wr_ptr_next = wr_ptr_reg + PW'(push_ok);
    count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
    // The head register is loaded one edge ahead. When the write slot is the
    // next read slot, the queue is (or becomes) empty before this push, so the
    // incoming command is the new head and the array is not yet written.
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = din;
    end else begin
      head_next = mem_reg[rd_ptr_next];
    end
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      head_next   = MV_NONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= MV_NONE;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

endmodule

// File: rtl/player_move_scheduler.sv
// player_move_scheduler
//   Buffers left/right key pulses in a small move queue and applies at most
//   one move per game tick to the registered, clamped player column. All
//   movement is suspended while freeze is high; entering the frozen state
//   flushes the queue, and leaving it consumes one idle tick.
//   Optional feature macro: AUTOREPEAT_EN (held keys inject synthetic pulses
//   every REPEAT_CYCLES cycles). Without it left_held/right_held are unused.
//   Ports:
//     CLK, RST                 : clock, synchronous active-high reset
//     left_pulse, right_pulse  : one-cycle move requests
//     tick                     : one-cycle game-frame strobe
//     freeze                   : level, high = paused / game over
//     left_held, right_held    : raw key levels (auto-repeat only)
//     player_col               : current player column, 0..COLS-1
//     moved                    : one-cycle pulse after player_col changed
//     queue_full               : queue holds DEPTH entries
//     drop_cnt                 : saturating count of requests lost to a full queue
module player_move_scheduler
  import player_pkg::*;
#(
  parameter int COLS          = 8,
  parameter int DEPTH         = 4,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     left_pulse,
  input  logic                     right_pulse,
  input  logic                     tick,
  input  logic                     freeze,
  input  logic                     left_held,
  input  logic                     right_held,
  output logic [$clog2(COLS)-1:0]  player_col,
  output logic                     moved,
  output logic                     queue_full,
  output logic [7:0]               drop_cnt
);

  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_INIT = CW'(COLS / 2);

  logic left_req, right_req;

`ifdef AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [1:0] held_vec;
  logic [1:0] syn_pulse;

  assign held_vec = {right_held, left_held};

  // Index 0 = left, 1 = right. A counter restarts whenever it fires or its
  // key is released, so a long hold yields one pulse every REPEAT_CYCLES.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
      logic [RW-1:0] rep_cnt_reg;

      assign syn_pulse[gi] = held_vec[gi] && (rep_cnt_reg == REP_LAST);

      always_ff @(posedge CLK) begin
        if (RST || !held_vec[gi] || syn_pulse[gi]) begin
          rep_cnt_reg <= '0;
        end else begin
          rep_cnt_reg <= rep_cnt_reg + RW'(1);
        end
      end
    end
  endgenerate

  // Synthetic pulses merge with the real ones, so opposite directions in the
  // same cycle cancel in the normal decode.
  assign left_req  = left_pulse  | syn_pulse[0];
  assign right_req = right_pulse | syn_pulse[1];
`else
  logic unused_held;
  assign unused_held = left_held ^ right_held;
  assign left_req    = left_pulse;
  assign right_req   = right_pulse;
`endif

  // ---------------------------------------------------------------- FSM
  state_t state_reg, state_next;
  logic   run_active;
  logic   flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (freeze) state_next = FROZEN;
      FROZEN:  if (tick && !freeze) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The cycle that enters FROZEN already suspends movement and flushes;
  // the tick that returns to RUN is spent leaving FROZEN and pops nothing.
  always_comb begin
    run_active = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      RUN: begin
        if (freeze) flush = 1'b1;
        else        run_active = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- queue
  move_t req_cmd;
  move_t fifo_head;
  logic  fifo_empty, fifo_full;
  logic  push, pop, drop;

  assign req_cmd = decode_req(left_req, right_req);
  assign push    = run_active && (req_cmd != MV_NONE);
  assign pop     = run_active && tick && !fifo_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign drop    = push && fifo_full && !pop;

  move_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (req_cmd),
    .pop   (pop),
    .flush (flush),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // ---------------------------------------------------------------- column
  logic [CW-1:0] col_reg, col_next;
  logic          moved_reg;
  logic [7:0]    drop_reg;

  // Clamped moves are still consumed by the pop; only the column stays put.
  always_comb begin
    col_next = col_reg;
    if (pop) begin
      case (fifo_head)
        MV_LEFT:  if (col_reg != '0)      col_next = col_reg - CW'(1);
        MV_RIGHT: if (col_reg != COL_MAX) col_next = col_reg + CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_reg   <= COL_INIT;
      moved_reg <= 1'b0;
      drop_reg  <= '0;
    end else begin
      col_reg   <= col_next;
      moved_reg <= (col_next != col_reg);
      if (drop && (drop_reg != DROP_MAX)) begin
        drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  assign player_col = col_reg;
  assign moved      = moved_reg;
  assign queue_full = fifo_full;
  assign drop_cnt   = drop_reg;

endmodule

// File: tb/tb_player_move_scheduler.sv
// tb_player_move_scheduler
//   Self-checking bench: a directed vector table, hand-written sequences for
//   drop saturation and held-key auto-repeat, and a randomized phase checked
//   against a queue-based behavioural model of the scheduler.
module tb_player_move_scheduler;

  localparam int COLS          = 8;
  localparam int DEPTH         = 4;
  localparam int REPEAT_CYCLES = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       left_pulse, right_pulse, tick, freeze, left_held, right_held;
  logic [2:0] player_col;
  logic       moved, queue_full;
  logic [7:0] drop_cnt;

  always #5 CLK = ~CLK;

  player_move_scheduler #(
    .COLS          (COLS),
    .DEPTH         (DEPTH),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .tick        (tick),
    .freeze      (freeze),
    .left_held   (left_held),
    .right_held  (right_held),
    .player_col  (player_col),
    .moved       (moved),
    .queue_full  (queue_full),
    .drop_cnt    (drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input bit lp, input bit rp, input bit tk, input bit fr,
                       input bit rs, input bit lh, input bit rh);
    left_pulse  = lp;
    right_pulse = rp;
    tick        = tk;
    freeze      = fr;
    RST         = rs;
    left_held   = lh;
    right_held  = rh;
    @(posedge CLK);
    #1;
  endtask

  // ------------------------------------------------------------ directed table
  typedef struct {
    bit lp, rp, tk, fr, rs;
    int col;
    bit mv, full;
    int drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit lp, input bit rp, input bit tk, input bit fr, input bit rs,
                     input int col, input bit mv, input bit full, input int drop);
    vec_t t;
    t.lp = lp; t.rp = rp; t.tk = tk; t.fr = fr; t.rs = rs;
    t.col = col; t.mv = mv; t.full = full; t.drop = drop;
    vecs.push_back(t);
  endtask

  // ------------------------------------------------------------ reference model
  int m_q[$];        // queued steps: -1 left, +1 right
  int m_col;
  int m_drop;
  bit m_frozen;
  bit m_moved;

  task automatic model_step(input bit lp, input bit rp, input bit tk, input bit fr, input bit rs);
    int step;
    int nc;
    step = 0;
    if (rs) begin
      m_q.delete();
      m_col = COLS / 2; m_drop = 0; m_frozen = 0; m_moved = 0;
    end else if (m_frozen) begin
      m_moved = 0;
      if (tk && !fr) m_frozen = 0;
    end else if (fr) begin
      m_q.delete();
      m_frozen = 1;
      m_moved  = 0;
    end else begin
      if (tk && m_q.size() > 0) step = m_q.pop_front();
      if (lp != rp) begin
        if (m_q.size() < DEPTH) m_q.push_back(lp ? -1 : 1);
        else if (m_drop < 255) m_drop++;
      end
      nc = m_col + step;
      if (nc < 0) nc = 0;
      if (nc > COLS - 1) nc = COLS - 1;
      m_moved = (nc != m_col);
      m_col   = nc;
    end
  endtask

`ifdef AUTOREPEAT_EN
  localparam int EXP_HOLD_COL = 6;
`else
  localparam int EXP_HOLD_COL = 4;
`endif

  initial begin
    bit lp, rp, tk, fr, rs;

    left_pulse = 0; right_pulse = 0; tick = 0; freeze = 0;
    left_held = 0; right_held = 0; RST = 1;

    //   lp rp tk fr rs   col mv full drop
    // right move, moved lasts one cycle
    add(0, 0, 0, 0, 1,   4, 0, 0, 0);
    add(0, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 0, 1, 0, 0,   5, 1, 0, 0);
    add(0, 0, 0, 0, 0,   5, 0, 0, 0);
    // walk to the right edge, then a clamped move
    add(0, 1, 0, 0, 0,   5, 0, 0, 0);
    add(0, 0, 1, 0, 0,   6, 1, 0, 0);
    add(0, 1, 0, 0, 0,   6, 0, 0, 0);
    add(0, 0, 1, 0, 0,   7, 1, 0, 0);
    add(0, 1, 0, 0, 0,   7, 0, 0, 0);
    add(0, 0, 1, 0, 0,   7, 0, 0, 0);
    add(0, 0, 1, 0, 0,   7, 0, 0, 0);
    // six lefts into a 4-deep queue, then drain to column 0
    add(0, 0, 0, 0, 1,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 1, 0);
    add(1, 0, 0, 0, 0,   4, 0, 1, 1);
    add(1, 0, 0, 0, 0,   4, 0, 1, 2);
    add(0, 0, 1, 0, 0,   3, 1, 0, 2);
    add(0, 0, 1, 0, 0,   2, 1, 0, 2);
    add(0, 0, 1, 0, 0,   1, 1, 0, 2);
    add(0, 0, 1, 0, 0,   0, 1, 0, 2);
    add(0, 0, 1, 0, 0,   0, 0, 0, 2);
    // simultaneous left+right cancels
    add(0, 0, 0, 0, 1,   4, 0, 0, 0);
    add(1, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 0, 1, 0, 0,   4, 0, 0, 0);
    // full queue with push and pop in the same cycle
    add(0, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 1, 0, 0, 0,   4, 0, 1, 0);
    add(0, 1, 1, 0, 0,   5, 1, 1, 0);
    add(0, 1, 0, 0, 0,   5, 0, 1, 1);
    // freeze flushes, blocks pushes, resume tick is idle
    add(0, 0, 0, 0, 1,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(0, 0, 0, 1, 0,   4, 0, 0, 0);
    add(1, 0, 1, 1, 0,   4, 0, 0, 0);
    add(0, 1, 0, 1, 0,   4, 0, 0, 0);
    add(0, 0, 0, 0, 0,   4, 0, 0, 0);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0);
    add(0, 0, 1, 0, 0,   4, 0, 0, 0);
    add(0, 0, 1, 0, 0,   4, 0, 0, 0);
    add(0, 1, 0, 0, 0,   4, 0, 0, 0);
    add(0, 0, 1, 0, 0,   5, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lp, vecs[i].rp, vecs[i].tk, vecs[i].fr, vecs[i].rs, 1'b0, 1'b0);
      $display("vec %0d: lp=%0d rp=%0d tick=%0d frz=%0d rst=%0d -> col=%0d moved=%0d full=%0d drop=%0d",
               i, vecs[i].lp, vecs[i].rp, vecs[i].tk, vecs[i].fr, vecs[i].rs,
               player_col, moved, queue_full, drop_cnt);
      chk("vec_col",   i, 32'(player_col), 32'(vecs[i].col));
      chk("vec_moved", i, 32'(moved),      32'(vecs[i].mv));
      chk("vec_full",  i, 32'(queue_full), 32'(vecs[i].full));
      chk("vec_drop",  i, 32'(drop_cnt),   32'(vecs[i].drop));
    end

    // ------------------------------------------------ drop counter saturation
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      if (i == 254) begin
        $display("sat: after 255 drops drop=%0d", drop_cnt);
        chk("drop_at_255", i, 32'(drop_cnt), 32'd255);
      end
    end
    $display("sat: after 256 drops drop=%0d", drop_cnt);
    chk("drop_saturated", 256, 32'(drop_cnt), 32'd255);
    drive(0, 0, 0, 0, 1, 0, 0);
    $display("sat: reset -> drop=%0d full=%0d", drop_cnt, queue_full);
    chk("drop_after_rst", 0, 32'(drop_cnt), 32'd0);
    chk("full_after_rst", 0, 32'(queue_full), 32'd0);

    // ------------------------------------------------ held-key auto-repeat
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0, 0, 1);
    $display("hold: 9 held cycles -> col=%0d", player_col);
    chk("hold_col", 9, 32'(player_col), 32'(EXP_HOLD_COL));
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 0, 0, 1);
    chk("hold_col_more", 11, 32'(player_col), 32'(EXP_HOLD_COL));
    drive(0, 0, 1, 0, 1, 0, 1);
    $display("hold: reset mid-hold -> col=%0d", player_col);
    chk("hold_rst_col", 0, 32'(player_col), 32'd4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 1);
      $display("hold: post-reset cycle %0d -> col=%0d", i, player_col);
      chk("hold_cnt_cleared", i, 32'(player_col), 32'd4);
    end
    drive(0, 0, 0, 0, 1, 0, 0);

    // ------------------------------------------------ randomized vs model
    model_step(0, 0, 0, 0, 1);
    fr = 0;
    for (int i = 0; i < 600; i++) begin
      lp = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 3) == 0);
      tk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) fr = !fr;
      rs = ($urandom_range(0, 99) == 0);
      model_step(lp, rp, tk, fr, rs);
      drive(lp, rp, tk, fr, rs, 1'b0, 1'b0);
      $display("rnd %0d: lp=%0d rp=%0d tick=%0d frz=%0d rst=%0d -> col=%0d/%0d moved=%0d/%0d full=%0d drop=%0d/%0d",
               i, lp, rp, tk, fr, rs, player_col, m_col, moved, m_moved,
               queue_full, drop_cnt, m_drop);
      chk("rnd_col",   i, 32'(player_col), 32'(m_col));
      chk("rnd_moved", i, 32'(moved),      32'(m_moved));
      chk("rnd_full",  i, 32'(queue_full), 32'(m_q.size() == DEPTH));
      chk("rnd_drop",  i, 32'(drop_cnt),   32'(m_drop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_move_scheduler.md
Name: player_move_scheduler

Overview:
- Sequences player movement for the asteroid avoider.
- Accepts single-cycle left/right key pulses from the key-pulse front ends.
- Buffers pulses in a small command queue and applies at most one move per game tick.
- Owns the registered player column, clamped to the playfield, and suspends all movement while the game is frozen (pause/game over).

Parameters:
- COLS, 8: playfield width in columns; player_col range 0..COLS-1.
- DEPTH, 4: move-queue depth in entries; power of two, minimum 2.
- REPEAT_CYCLES, 25000000: hold time in cycles per auto-repeat step (used only with AUTOREPEAT_EN).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- left_pulse  in  1  one-cycle move-left request.
- right_pulse  in  1  one-cycle move-right request.
- tick  in  1  one-cycle game-frame strobe.
- freeze  in  1  level; high = paused/game over.
- left_held  in  1  raw left key level (used only with AUTOREPEAT_EN).
- right_held  in  1  raw right key level (used only with AUTOREPEAT_EN).
- player_col  out  $clog2(COLS)  current player column.
- moved  out  1  one-cycle pulse when player_col changed.
- queue_full  out  1  queue holds DEPTH entries.
- drop_cnt  out  8  saturating count of requests dropped because the queue was full.

Behaviour:
- The interface has one clock, CLK, and the reset RST is synchronous and active-high.
- Reset values:
  - player_col = COLS/2.
  - Queue empty; queue_full = 0.
  - drop_cnt = 0.
  - moved = 0.
  - State = RUN.
  - Repeat counters = 0.
- Request decode, per cycle:
  - left_pulse only -> MV_LEFT.
  - right_pulse only -> MV_RIGHT.
  - Both high -> cancel; nothing is enqueued and nothing is counted.
  - Neither high -> nothing.
- Enqueue, in RUN only:
  - Not full -> the command is written at the tail.
  - Full and no pop in the same cycle -> the command is dropped and drop_cnt increments, saturating at 255.
  - Full with a pop in the same cycle -> the push is accepted and nothing is dropped.
- Pop: occurs when tick=1, state is RUN, and the queue is not empty. The head command is removed.
- Update:
  - The popped MV_LEFT decrements player_col; MV_RIGHT increments it.
  - player_col clamps at 0 and COLS-1. A clamped move is still consumed.
  - player_col updates on the edge ending the tick cycle.
  - moved=1 in the following cycle only if the value actually changed.
- No bypass: a push in the same cycle as a tick on an empty queue is applied at the next tick.
  - Minimum latency is 1 tick; maximum is DEPTH ticks.
- queue_full is registered and reflects the occupancy after the current cycle's push/pop.
- State machine:
  - RUN -> FROZEN when freeze=1. On entry, the queue is flushed in that same cycle.
  - FROZEN: pushes are ignored and not counted as drops; player_col is held; moved=0.
  - FROZEN -> RUN on the first tick with freeze=0. That tick pops nothing.
- Reset mid-operation restores all reset values on the next edge, regardless of state or queue contents.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - Each direction has a counter that clears when its held input is low.
  - While the held input stays high, the counter counts to REPEAT_CYCLES-1. At that count the block injects a synthetic pulse for that direction and the counter restarts from 0.
  - Synthetic pulses follow identical decode, cancel, drop and freeze rules. If both synthetic pulses occur in the same cycle, they cancel.
- Not defined:
  - left_held and right_held are ignored.
  - No counters are synthesized; behaviour is otherwise identical.

Decomposition:
- Package player_pkg:
  - typedef enum move_t {MV_NONE, MV_LEFT, MV_RIGHT}, 2 bits.
  - typedef enum state_t {RUN, FROZEN}.
  - DROP_MAX = 8'hFF.
- Sub-module move_fifo: DEPTH-entry synchronous FIFO of move_t.
  - Inputs: push, pop, flush.
  - Outputs: head, empty, full.
  - Pointer wrap via $clog2(DEPTH)-bit pointers plus a count register.

Test Plan:
1. Reset, then right_pulse, then tick -> player_col 4->5; moved high for exactly 1 cycle after the tick.
2. player_col=7, right_pulse, tick -> player_col stays 7; moved=0; queue empty afterwards.
3. 6 left pulses with no tick (DEPTH=4) -> queue_full=1, drop_cnt=2; 4 ticks then move player_col 4->0, one step per tick.
4. left_pulse and right_pulse in the same cycle, then tick -> no change; drop_cnt unchanged; queue empty.
5. 3 queued moves, assert freeze, pulse keys and ticks, deassert freeze, then 2 ticks -> queue flushed; player_col unchanged through the first tick; the second tick is idle as well.
6. With AUTOREPEAT_EN and REPEAT_CYCLES=4, hold right_held for 9 cycles with ticks every cycle -> 2 synthetic moves, player_col 4->6; RST pulsed mid-hold -> player_col=4 and counters cleared.
